instr_assembler: RTL
====================

// Module: instr_assembler
// PURPOSE
//  Front-end byte-stream instruction assembler; successor to the combinational opcode class table.
//  Classifies each opcode byte, derives total instruction length and collects the following operand
//  bytes from a valid/ready byte stream. Emits one whole instruction per handshake to the decoder.
//  Sits between the fetch byte queue and the decode stage.
// PARAMETERS
//  BYTE_W        8        width of one stream byte; opcode is the first byte, only its [7:0] are classified
//  IMM_BYTES     1        immediate length in bytes for NormalImm / ExtOpImm (1..4)
//  NORM_IMM_MASK 16'h0E00 bit i set => opcode[7:4]==i is NormalImm (0..11 only; 12..15 are extended)
//  EXT_IMM_MASK  16'h7C8C bit i set => extended opcode with opcode[5:2]==i is ExtOpImm, else ExtOp
//  MAX_LEN       2+IMM_BYTES  derived; maximum instruction length in bytes (localparam)
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  rst_n        in   1                  asynchronous active-low reset
//  flush        in   1                  synchronous redirect; drops partial and held instruction
//  in_valid     in   1                  stream byte valid
//  in_ready     out  1                  assembler accepts in_byte this cycle
//  in_byte      in   BYTE_W             stream byte
//  instr_valid  out  1                  assembled instruction available
//  instr_ready  in   1                  decoder consumes instruction
//  instr_bytes  out  MAX_LEN*BYTE_W     byte k at [k*BYTE_W +: BYTE_W]; byte 0 = opcode; unused bytes = 0
//  instr_len    out  $clog2(MAX_LEN+1)  total bytes in instruction (1..MAX_LEN)
//  instr_t      out  InstrType          class of held instruction
// BEHAVIOUR
//  Reset: instr_valid=0, instr_bytes=0, instr_len=0, instr_t=Normal, in_ready=1, FSM=OPCODE, count=0.
//  Class: top nibble <12 -> Normal, or NormalImm if NORM_IMM_MASK[nibble]; >=12 -> ExtOp/ExtOpImm by EXT_IMM_MASK[opcode[5:2]].
//  Length: Normal 1; NormalImm 1+IMM_BYTES; ExtOp 2 (opcode + register byte); ExtOpImm 2+IMM_BYTES.
//  Handshake: byte transfers when in_valid&&in_ready; instruction transfers when instr_valid&&instr_ready.
//  in_ready = !flush && (!instr_valid || instr_ready); combinational, no in_valid->in_ready path.
//  FSM OPCODE: accepted byte is opcode; stored in slot 0, len latched; len==1 -> HOLD else COLLECT, count=1.
//  FSM COLLECT: each accepted byte -> slot[count], count++; count+1==len -> HOLD.
//  FSM HOLD: instr_valid=1; outputs stable until consumed. Consume w/o new byte -> OPCODE, slots cleared.
//  Consume and accept byte same cycle: byte treated as a new opcode (back-to-back, no bubble).
//  Latency: last byte accepted in cycle N -> instr_valid in N+1. Peak 1 instr/cycle for 1-byte ops.
//  instr_valid never drops without instr_ready or flush; payload never changes while valid&&!ready.
//  in_valid low mid-instruction: FSM waits in COLLECT indefinitely, count held.
//  flush: highest priority; next cycle FSM=OPCODE, count=0, instr_valid=0, slots=0; no byte accepted and
//   no instruction consumed in the flush cycle. Async reset mid-instruction: immediate return to reset values.
//  count width $clog2(MAX_LEN+1); never exceeds len-1 in COLLECT; no wrap possible.
// STRUCTURE
//  Package smolproc_pkg: typedef InstrType {Normal,NormalImm,ExtOp,ExtOpImm}; function instr_length(InstrType,imm_bytes).
//  Sub-module opcode_classifier: combinational opcode->InstrType using the two mask parameters.
//  Top: FSM enum {OPCODE,COLLECT,HOLD}, slot registers, count, handshake logic.
// TESTING
//  Defaults; stream 0x12,0x34 ready=1 -> two Normal, len 1, bytes 0x12/0x34, consecutive cycles.
//  Stream 0x95,0xAB -> one NormalImm, len 2, instr_bytes={0x00,0xAB,0x95}, valid 1 cycle after 0xAB.
//  Stream 0xC8,0x03,0x7F (ext sub 2) -> ExtOpImm len 3; 0xC4,0x05 (sub 1) -> ExtOp len 2.
//  instr_ready=0 for 5 cycles with valid held -> in_ready=0, payload stable, then drains on ready.
//  flush after 0xC8,0x03 accepted -> no instr_valid; next byte 0x01 emits Normal len 1.
//  IMM_BYTES=2: 0xA0,0x11,0x22 -> NormalImm len 3; assert rst_n low mid-COLLECT -> all outputs reset same cycle.

Source files
------------

// File: rtl/smolproc_pkg.sv
// Shared types and helpers for the byte-stream instruction front end.
package smolproc_pkg;

    // Instruction class derived from the opcode byte.
    typedef enum logic [1:0] {
        Normal    = 2'd0,
        NormalImm = 2'd1,
        ExtOp     = 2'd2,
        ExtOpImm  = 2'd3
    } InstrType;

    // Total instruction length in bytes, opcode included.
    function automatic int unsigned instr_length(input InstrType t, input int unsigned imm_bytes);
        int unsigned len;
        case (t)
            Normal:    len = 1;
            NormalImm: len = 1 + imm_bytes;
            ExtOp:     len = 2;
            default:   len = 2 + imm_bytes;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier: top nibble selects plain vs extended space,
// the two masks mark which opcodes carry an immediate.
module opcode_classifier
    import smolproc_pkg::*;
#(
    parameter logic [15:0] NORM_IMM_MASK = 16'h0E00,
    parameter logic [15:0] EXT_IMM_MASK  = 16'h7C8C
) (
    input  logic [7:0] opcode,
    output InstrType   itype
);

    logic [3:0] nibble;
    logic [3:0] ext_sub;
    logic       unused_low_bits;

    assign nibble          = opcode[7:4];
    assign ext_sub         = opcode[5:2];
    assign unused_low_bits = ^opcode[1:0];

    // Nibbles 12..15 form the extended space, classified by the sub-opcode field.
    always_comb begin
        itype = Normal;
        if (nibble < 4'd12) begin
            itype = NORM_IMM_MASK[nibble] ? NormalImm : Normal;
        end else begin
            itype = EXT_IMM_MASK[ext_sub] ? ExtOpImm : ExtOp;
        end
    end

endmodule

// File: rtl/instr_assembler.sv
// Byte-stream instruction assembler: collects opcode plus operand bytes from a
// valid/ready byte stream and presents one whole instruction per handshake.
module instr_assembler
    import smolproc_pkg::*;
#(
    parameter int unsigned BYTE_W        = 8,
    parameter int unsigned IMM_BYTES     = 1,
    parameter logic [15:0] NORM_IMM_MASK = 16'h0E00,
    parameter logic [15:0] EXT_IMM_MASK  = 16'h7C8C,
    localparam int unsigned MAX_LEN      = 2 + IMM_BYTES,
    localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BYTE_W-1:0]         in_byte,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [MAX_LEN*BYTE_W-1:0] instr_bytes,
    output logic [LEN_W-1:0]          instr_len,
    output InstrType                  instr_t
);

    typedef enum logic [1:0] {
        OPCODE  = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } asm_state_t;

    asm_state_t                       state_q, state_d;
    logic [LEN_W-1:0]                 count_q, count_d;
    logic [LEN_W-1:0]                 len_q, len_d;
    logic [MAX_LEN-1:0][BYTE_W-1:0]   slots_q, slots_d;
    InstrType                         type_q, type_d;

    InstrType                         op_type;
    logic [LEN_W-1:0]                 op_len;
    logic [LEN_W-1:0]                 count_inc;
    logic                             accept;
    logic                             consume;
    logic                             load_op;

    opcode_classifier #(
        .NORM_IMM_MASK (NORM_IMM_MASK),
        .EXT_IMM_MASK  (EXT_IMM_MASK)
    ) u_classifier (
        .opcode (in_byte[7:0]),
        .itype  (op_type)
    );

    assign op_len      = LEN_W'(instr_length(op_type, IMM_BYTES));
    assign count_inc   = count_q + LEN_W'(1);

    assign instr_valid = (state_q == HOLD);
    assign in_ready    = !flush && (!instr_valid || instr_ready);
    assign accept      = in_valid && in_ready;
    assign consume     = instr_valid && instr_ready && !flush;

    assign instr_bytes = slots_q;
    assign instr_len   = len_q;
    assign instr_t     = type_q;

    // Next-state, slot and length update; flush overrides everything.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        slots_d = slots_q;
        type_d  = type_q;
        load_op = 1'b0;

        if (flush) begin
            state_d = OPCODE;
            count_d = '0;
            len_d   = '0;
            slots_d = '0;
            type_d  = Normal;
        end else begin
            case (state_q)
                OPCODE: begin
                    load_op = accept;
                end
                COLLECT: begin
                    if (accept) begin
                        for (int unsigned k = 0; k < MAX_LEN; k++) begin
                            if (count_q == LEN_W'(k)) begin
                                slots_d[k] = in_byte;
                            end
                        end
                        count_d = count_inc;
                        if (count_inc == len_q) begin
                            state_d = HOLD;
                            count_d = '0;
                        end
                    end
                end
                HOLD: begin
                    // A byte accepted here implies the held instruction is
                    // consumed on the same edge, so it starts the next one.
                    if (accept) begin
                        load_op = 1'b1;
                    end else if (consume) begin
                        state_d = OPCODE;
                        count_d = '0;
                        len_d   = '0;
                        slots_d = '0;
                        type_d  = Normal;
                    end
                end
                default: begin
                    state_d = OPCODE;
                end
            endcase

            if (load_op) begin
                slots_d    = '0;
                slots_d[0] = in_byte;
                len_d      = op_len;
                type_d     = op_type;
                if (op_len == LEN_W'(1)) begin
                    state_d = HOLD;
                    count_d = '0;
                end else begin
                    state_d = COLLECT;
                    count_d = LEN_W'(1);
                end
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OPCODE;
            count_q <= '0;
            len_q   <= '0;
            slots_q <= '0;
            type_q  <= Normal;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            slots_q <= slots_d;
            type_q  <= type_d;
        end
    end

endmodule
